keep_watchdog: RTL

- Consumes the "alive" side of the keep-timer scheme. After power-up release, the Tetris game logic must pulse iKICK periodically.
- If kicks stop, the block raises a warning, then asserts oRESET for a fixed pulse width so the game core restarts.
- It then holds off briefly before re-arming.
- Sits beside the power-on reset generator; its oRESET is ORed into the game-core reset.

---
 rtl/keep_pkg.sv | 20 ++
 rtl/keep_pulse_stretch.sv | 41 ++++
 rtl/keep_watchdog.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/keep_pkg.sv
// Shared constants for the keep-alive watchdog and the power-on keep timer.
// State encoding and default timing live here so both blocks agree.
package keep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_WARN = 3'd2,
    ST_BITE = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  localparam int unsigned KEEP_CNT_W    = 20;
  localparam int unsigned KEEP_TIMEOUT  = 32'h000F_FFFF;
  localparam int unsigned KEEP_WARN_AT  = 32'h000C_0000;
  localparam int unsigned KEEP_BITE_LEN = 16;
  localparam int unsigned KEEP_HOLDOFF  = 64;
  localparam int unsigned KEEP_BITES_W  = 8;

endpackage

// File: rtl/keep_pulse_stretch.sv
// Fixed-width pulse generator: i_start opens a window of exactly LEN cycles (o_busy),
// o_done marks its final cycle. i_abort closes the window early.
module keep_pulse_stretch #(
  parameter int unsigned LEN = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_abort,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned W = (LEN > 1) ? $clog2(LEN) : 1;

  logic [W-1:0] r_left;
  logic         r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_left <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_left <= W'(LEN - 1);
      r_busy <= 1'b1;
    end else if (i_abort) begin
      r_left <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (r_left == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_left <= r_left - W'(1);
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_left == '0);

endmodule

// File: rtl/keep_watchdog.sv
// Keep-alive watchdog: warns, then bites the game-core reset when kicks stop,
// then holds off before re-arming. All outputs registered.
module keep_watchdog
  import keep_pkg::*;
#(
  parameter int unsigned CNT_W    = KEEP_CNT_W,
  parameter int unsigned TIMEOUT  = KEEP_TIMEOUT,
  parameter int unsigned WARN_AT  = KEEP_WARN_AT,
  parameter int unsigned BITE_LEN = KEEP_BITE_LEN,
  parameter int unsigned HOLDOFF  = KEEP_HOLDOFF,
  parameter int unsigned BITES_W  = KEEP_BITES_W
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iENABLE,
  input  logic               iKICK,
  output logic               oRESET,
  output logic               oWARN,
  output logic [2:0]         oSTATE,
  output logic [CNT_W-1:0]   oCOUNT,
  output logic [BITES_W-1:0] oBITES
);

  localparam logic [CNT_W-1:0] LP_WARN_PRE = CNT_W'(WARN_AT - 1);
  localparam logic [CNT_W-1:0] LP_TERM     = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_reset;
  logic               r_warn;
  logic [BITES_W-1:0] r_bites;

  logic w_bite_busy, w_bite_done, w_hold_busy, w_hold_done;
  logic w_kick, w_bite_start, w_hold_start, w_hold_abort;

  // Kicks mean nothing while either phase timer is running.
  assign w_kick       = iKICK && !w_bite_busy && !w_hold_busy;
  assign w_bite_start = (r_state == ST_WARN) && iENABLE && !w_kick && (r_count == LP_TERM);
  assign w_hold_start = (r_state == ST_BITE) && w_bite_done && iENABLE;
  assign w_hold_abort = (r_state == ST_HOLD) && !iENABLE;

  keep_pulse_stretch #(.LEN(BITE_LEN)) u_bite (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_start (w_bite_start),
    .i_abort (1'b0),
    .o_busy  (w_bite_busy),
    .o_done  (w_bite_done)
  );

  keep_pulse_stretch #(.LEN(HOLDOFF)) u_hold (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_start (w_hold_start),
    .i_abort (w_hold_abort),
    .o_busy  (w_hold_busy),
    .o_done  (w_hold_done)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_reset <= 1'b0;
      r_warn  <= 1'b0;
      r_bites <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          r_reset <= 1'b0;
          r_warn  <= 1'b0;
          if (iENABLE) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!iENABLE) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_warn  <= 1'b0;
          end else if (w_kick) begin
            r_count <= '0;
          end else begin
            r_count <= r_count + CNT_W'(1);
            if (r_count == LP_WARN_PRE) begin
              r_state <= ST_WARN;
              r_warn  <= 1'b1;
            end
          end
        end
        ST_WARN: begin
          if (!iENABLE) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_warn  <= 1'b0;
          end else if (w_kick) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_warn  <= 1'b0;
          end else if (w_bite_start) begin
            r_state <= ST_BITE;
            r_count <= '0;
            r_warn  <= 1'b0;
            r_reset <= 1'b1;
            if (r_bites != '1) r_bites <= r_bites + BITES_W'(1);
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_BITE: begin
          // The pulse always runs to completion; enable only picks the exit.
          if (w_bite_done) begin
            r_state <= iENABLE ? ST_HOLD : ST_IDLE;
            r_count <= '0;
            r_reset <= 1'b0;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          r_count <= '0;
          if (!iENABLE) begin
            r_state <= ST_IDLE;
            r_warn  <= 1'b0;
          end else if (w_hold_done) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
          r_reset <= 1'b0;
          r_warn  <= 1'b0;
        end
      endcase
    end
  end

  assign oRESET = r_reset;
  assign oWARN  = r_warn;
  assign oSTATE = r_state;
  assign oCOUNT = r_count;
  assign oBITES = r_bites;

endmodule
